// File: rtl/regfile_mp_pkg.sv
// Shared core parameter package.
// Holds the datapath-wide defaults that the register file and its scoreboard
// take as their parameter defaults, plus a small address-width helper.
package regfile_mp_pkg;

    localparam int CORE_XLEN  = 32;   // architectural register width
    localparam int CORE_NREGS = 32;   // architectural register count
    localparam int CORE_NRD   = 2;    // register-file read ports
    localparam int CORE_NWR   = 2;    // register-file write ports

    // Address width for a power-of-two register count (at least 1 bit).
    function automatic int addr_w(input int nregs);
        return (nregs <= 2) ? 1 : $clog2(nregs);
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-writeback scoreboard for the register file.
// Tracks which registers have an issued-but-not-written-back producer and
// keeps a registered count of them.
//
// Ports:
//   clk, rst    - clock and synchronous active-high reset
//   iss_en      - issue strobe; marks iss_addr pending
//   iss_addr    - destination register of the issued instruction
//   wr_en       - per-port writeback enables
//   wr_addr     - per-port writeback addresses, port k in slice k
//   pending     - one bit per register; bit 0 is always 0
//   pend_cnt    - popcount of pending, lagging the vector by one cycle
module regfile_scoreboard
    import regfile_mp_pkg::*;
#(
    parameter int NREGS = CORE_NREGS,
    parameter int NWR   = CORE_NWR
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 iss_en,
    input  logic [addr_w(NREGS)-1:0]             iss_addr,
    input  logic [NWR-1:0]                       wr_en,
    input  logic [NWR*addr_w(NREGS)-1:0]         wr_addr,
    output logic [NREGS-1:0]                     pending,
    output logic [addr_w(NREGS):0]               pend_cnt
);

    localparam int AW = addr_w(NREGS);

    logic [NREGS-1:0] pending_nxt;

    // Counts registers 1..NREGS-1; register 0 can never be pending.
    function automatic logic [AW:0] popcount(input logic [NREGS-1:0] v);
        logic [AW:0] c;
        c = '0;
        for (int i = 1; i < NREGS; i++) begin
            c = c + {{AW{1'b0}}, v[i]};
        end
        return c;
    endfunction

    // Writebacks clear first, then an issue sets: a same-cycle issue to the
    // register being written back names a newer producer, so it must stay
    // pending.
    always_comb begin
        pending_nxt = pending;
        for (int k = 0; k < NWR; k++) begin
            if (wr_en[k] && (wr_addr[k*AW +: AW] != '0)) begin
                pending_nxt[wr_addr[k*AW +: AW]] = 1'b0;
            end
        end
        if (iss_en && (iss_addr != '0)) begin
            pending_nxt[iss_addr] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    // pend_cnt samples the current vector, so it follows pending by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending  <= '0;
            pend_cnt <= '0;
        end else begin
            pending  <= pending_nxt;
            pend_cnt <= popcount(pending);
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-ported integer register file with optional write-to-read forwarding
// and a pending-writeback scoreboard.
//
// Ports:
//   clk, rst    - clock and synchronous active-high reset
//   rd_addr     - read addresses, port p in slice p
//   rd_data     - combinational read data, port p in slice p
//   rd_pending  - addressed register still awaits writeback
//   wr_en       - per-port write enables
//   wr_addr     - per-port write addresses
//   wr_data     - per-port write data
//   iss_en      - issue strobe; marks iss_addr pending
//   iss_addr    - destination of the issued instruction
//   pend_cnt    - registered count of pending registers
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int XLEN   = CORE_XLEN,
    parameter int NREGS  = CORE_NREGS,
    parameter int NRD    = CORE_NRD,
    parameter int NWR    = CORE_NWR,
    parameter int BYPASS = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NRD*addr_w(NREGS)-1:0]     rd_addr,
    output logic [NRD*XLEN-1:0]              rd_data,
    output logic [NRD-1:0]                   rd_pending,
    input  logic [NWR-1:0]                   wr_en,
    input  logic [NWR*addr_w(NREGS)-1:0]     wr_addr,
    input  logic [NWR*XLEN-1:0]              wr_data,
    input  logic                             iss_en,
    input  logic [addr_w(NREGS)-1:0]         iss_addr,
    output logic [addr_w(NREGS):0]           pend_cnt
);

    localparam int AW = addr_w(NREGS);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] pending;

    // Ascending port order makes the highest-index port's write land last,
    // so it wins when several ports hit the same register.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int k = 0; k < NWR; k++) begin
                if (wr_en[k] && (wr_addr[k*AW +: AW] != '0)) begin
                    regs[wr_addr[k*AW +: AW]] <= wr_data[k*XLEN +: XLEN];
                end
            end
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0]   a;
        logic [XLEN-1:0] d;
        logic            fwd;

        assign a = rd_addr[p*AW +: AW];

        // Register 0 is forced to zero here rather than relying on its storage,
        // so it reads 0 even before the first reset.
        always_comb begin
            d   = regs[a];
            fwd = 1'b0;
            if (BYPASS != 0) begin
                for (int k = 0; k < NWR; k++) begin
                    if (wr_en[k] && (wr_addr[k*AW +: AW] == a) && (a != '0)) begin
                        d   = wr_data[k*XLEN +: XLEN];
                        fwd = 1'b1;
                    end
                end
            end
            if (a == '0) begin
                d = '0;
            end
        end

        assign rd_data[p*XLEN +: XLEN] = d;
        // A forwarded value is the writeback itself, so the reader need not wait.
        assign rd_pending[p] = pending[a] && !fwd && (a != '0);
    end

    regfile_scoreboard #(
        .NREGS (NREGS),
        .NWR   (NWR)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .pending  (pending),
        .pend_cnt (pend_cnt)
    );

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;
    localparam int NRD   = 2;
    localparam int NWR   = 2;

    logic                clk;
    logic                rst;
    logic [AW-1:0]       ra [NRD];
    logic [NWR-1:0]      wr_en;
    logic [AW-1:0]       wa [NWR];
    logic [XLEN-1:0]     wd [NWR];
    logic                iss_en;
    logic [AW-1:0]       iss_addr;

    logic [NRD*AW-1:0]   rd_addr;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;

    logic [NRD*XLEN-1:0] rd_data_b, rd_data_n;
    logic [NRD-1:0]      rd_pend_b, rd_pend_n;
    logic [AW:0]         cnt_b, cnt_n;

    assign rd_addr = {ra[1], ra[0]};
    assign wr_addr = {wa[1], wa[0]};
    assign wr_data = {wd[1], wd[0]};

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_pending(rd_pend_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .pend_cnt(cnt_b)
    );

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_pending(rd_pend_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .pend_cnt(cnt_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: architectural register contents, pending set, and the
    // count of pending registers as it stood before the latest edge.
    logic [XLEN-1:0] mem [NREGS];
    bit              pend [NREGS];
    int              cnt_q;
    bit              model_valid;

    int total;
    int bad;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int count_pending();
        int c = 0;
        for (int i = 1; i < NREGS; i++) c += pend[i] ? 1 : 0;
        return c;
    endfunction

    task automatic model_edge();
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i]  = '0;
                pend[i] = 1'b0;
            end
            cnt_q       = 0;
            model_valid = 1'b1;
        end else begin
            cnt_q = count_pending();
            for (int k = 0; k < NWR; k++) begin
                if (wr_en[k] && wa[k] != 0) begin
                    mem[wa[k]]  = wd[k];
                    pend[wa[k]] = 1'b0;
                end
            end
            if (iss_en && iss_addr != 0) pend[iss_addr] = 1'b1;
        end
    endtask

    task automatic exp_read(input int a, input bit byp, output logic [XLEN-1:0] d, output logic pd);
        d  = (a == 0) ? '0 : mem[a];
        pd = (a != 0) && pend[a];
        if (byp && a != 0) begin
            for (int k = 0; k < NWR; k++) begin
                if (wr_en[k] && int'(wa[k]) == a) begin
                    d  = wd[k];
                    pd = 1'b0;
                end
            end
        end
    endtask

    task automatic check_reads();
        logic [XLEN-1:0] d;
        logic            pd;
        if (!model_valid) return;
        for (int p = 0; p < NRD; p++) begin
            exp_read(int'(ra[p]), 1'b1, d, pd);
            chk($sformatf("byp_data p%0d a%0d", p, ra[p]), 64'(rd_data_b[p*XLEN +: XLEN]), 64'(d));
            chk($sformatf("byp_pend p%0d a%0d", p, ra[p]), 64'(rd_pend_b[p]), 64'(pd));
            exp_read(int'(ra[p]), 1'b0, d, pd);
            chk($sformatf("nb_data p%0d a%0d", p, ra[p]), 64'(rd_data_n[p*XLEN +: XLEN]), 64'(d));
            chk($sformatf("nb_pend p%0d a%0d", p, ra[p]), 64'(rd_pend_n[p]), 64'(pd));
        end
    endtask

    // Inputs are applied at the falling edge; outputs are checked 1 time unit
    // later, then again after the following rising edge.
    task automatic cycle();
        #1;
        check_reads();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        if (model_valid) begin
            chk("pend_cnt_byp", 64'(cnt_b), 64'(cnt_q));
            chk("pend_cnt_nb", 64'(cnt_n), 64'(cnt_q));
        end
    endtask

    task automatic idle_inputs();
        wr_en  = '0;
        iss_en = 1'b0;
        for (int k = 0; k < NWR; k++) begin
            wa[k] = '0;
            wd[k] = '0;
        end
        iss_addr = '0;
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        cnt_q       = 0;
        model_valid = 1'b0;
        rst         = 1'b1;
        ra[0]       = '0;
        ra[1]       = '0;
        idle_inputs();

        // r0 reads zero before any reset has happened.
        #1;
        chk("r0_pre_reset_p0", 64'(rd_data_b[31:0]), 64'h0);
        chk("r0_pre_reset_p1", 64'(rd_data_n[63:32]), 64'h0);
        cycle();
        chk("reset_cnt", 64'(cnt_b), 64'h0);
        chk("reset_pend", 64'(rd_pend_b), 64'h0);
        rst = 1'b0;
        cycle();

        // Write r5 on port 0, read it back the next cycle.
        wr_en = 2'b01; wa[0] = 5'd5; wd[0] = 32'hDEADBEEF; ra[0] = 5'd5;
        cycle();
        idle_inputs();
        #1;
        chk("r5_readback_byp", 64'(rd_data_b[31:0]), 64'hDEADBEEF);
        chk("r5_readback_nb", 64'(rd_data_n[31:0]), 64'hDEADBEEF);

        // Writes to r0 are dropped.
        wr_en = 2'b01; wa[0] = 5'd0; wd[0] = 32'h1234; ra[0] = 5'd0;
        cycle();
        idle_inputs();
        #1;
        chk("r0_after_write", 64'(rd_data_b[31:0]), 64'h0);

        // Same-cycle write and read of r7.
        wr_en = 2'b01; wa[0] = 5'd7; wd[0] = 32'hA5A5A5A5; ra[1] = 5'd7;
        #1;
        chk("r7_forward_byp", 64'(rd_data_b[63:32]), 64'hA5A5A5A5);
        chk("r7_forward_nb", 64'(rd_data_n[63:32]), 64'h0);
        cycle();
        idle_inputs();
        #1;
        chk("r7_next_nb", 64'(rd_data_n[63:32]), 64'hA5A5A5A5);

        // Both ports write r3; port 1 wins.
        wr_en = 2'b11; wa[0] = 5'd3; wd[0] = 32'h11; wa[1] = 5'd3; wd[1] = 32'h22; ra[0] = 5'd3;
        #1;
        chk("r3_forward_byp", 64'(rd_data_b[31:0]), 64'h22);
        cycle();
        idle_inputs();
        #1;
        chk("r3_collision", 64'(rd_data_b[31:0]), 64'h22);
        chk("r3_collision_nb", 64'(rd_data_n[31:0]), 64'h22);

        // Issue r9 then write it back.
        iss_en = 1'b1; iss_addr = 5'd9; ra[0] = 5'd9;
        cycle();
        idle_inputs();
        #1;
        chk("r9_pending", 64'(rd_pend_b[0]), 64'h1);
        chk("r9_cnt_lag", 64'(cnt_b), 64'h0);
        cycle();
        chk("r9_cnt", 64'(cnt_b), 64'h1);
        wr_en = 2'b10; wa[1] = 5'd9; wd[1] = 32'h99;
        #1;
        chk("r9_pend_fwd_byp", 64'(rd_pend_b[0]), 64'h0);
        chk("r9_pend_fwd_nb", 64'(rd_pend_n[0]), 64'h1);
        cycle();
        idle_inputs();
        #1;
        chk("r9_cleared", 64'(rd_pend_b[0]), 64'h0);
        cycle();
        chk("r9_cnt_zero", 64'(cnt_b), 64'h0);
        // Issue and writeback of r9 in the same cycle: issue wins.
        iss_en = 1'b1; iss_addr = 5'd9; wr_en = 2'b01; wa[0] = 5'd9; wd[0] = 32'h77;
        cycle();
        idle_inputs();
        #1;
        chk("r9_set_wins", 64'(rd_pend_n[0]), 64'h1);
        chk("r9_set_wins_data", 64'(rd_data_n[31:0]), 64'h77);

        // Issue r1..r31.
        for (int i = 1; i < NREGS; i++) begin
            iss_en = 1'b1; iss_addr = AW'(i);
            cycle();
        end
        idle_inputs();
        cycle();
        chk("all_pending_cnt", 64'(cnt_b), 64'd31);
        // Re-issue of a pending register leaves the count alone.
        iss_en = 1'b1; iss_addr = 5'd5;
        cycle();
        idle_inputs();
        cycle();
        chk("reissue_cnt", 64'(cnt_b), 64'd31);

        // Reset with writes and an issue in flight.
        rst = 1'b1; wr_en = 2'b11; wa[0] = 5'd10; wd[0] = 32'hCAFE; wa[1] = 5'd5; wd[1] = 32'hBEEF;
        iss_en = 1'b1; iss_addr = 5'd12;
        cycle();
        rst = 1'b0;
        idle_inputs();
        chk("rst_cnt", 64'(cnt_b), 64'h0);
        ra[0] = 5'd10; ra[1] = 5'd5;
        #1;
        chk("rst_r10", 64'(rd_data_b[31:0]), 64'h0);
        chk("rst_r5", 64'(rd_data_b[63:32]), 64'h0);
        chk("rst_pend", 64'(rd_pend_b), 64'h0);
        ra[0] = 5'd3; ra[1] = 5'd12;
        #1;
        chk("rst_r3", 64'(rd_data_n[31:0]), 64'h0);
        chk("rst_pend12", 64'(rd_pend_n), 64'h0);

        // Random traffic with colliding addresses.
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 59) == 0);
            for (int k = 0; k < NWR; k++) begin
                wa[k] = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
                wd[k] = $urandom;
            end
            wr_en = NWR'($urandom);
            iss_en = ($urandom_range(0, 2) != 0);
            iss_addr = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
            for (int p = 0; p < NRD; p++) begin
                ra[p] = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
            end
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter XLEN, default 32: register data width in bits.
REQ-002 SHALL have parameter NREGS, default 32: register count (power of two, >=2); AW = log2(NREGS).
REQ-003 SHALL have parameter NRD, default 2: number of read ports.
REQ-004 SHALL have parameter NWR, default 2: number of write ports.
REQ-005 SHALL have parameter BYPASS, default 1: 1 enables write-to-read forwarding, 0 disables it.
REQ-006 SHALL have port clk, input, 1: clock, all state updates on its rising edge.
REQ-007 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-008 SHALL have port rd_addr, input, NRD*AW: read addresses, port p in slice p.
REQ-009 SHALL have port rd_data, output, NRD*XLEN: read data per port.
REQ-010 SHALL have port rd_pending, output, NRD: addressed register awaits writeback.
REQ-011 SHALL have port wr_en, input, NWR: write enables.
REQ-012 SHALL have port wr_addr, input, NWR*AW: write addresses.
REQ-013 SHALL have port wr_data, input, NWR*XLEN: write data.
REQ-014 SHALL have port iss_en, input, 1: issue strobe, marks iss_addr pending.
REQ-015 SHALL have port iss_addr, input, AW: destination register of issued instruction.
REQ-016 SHALL have port pend_cnt, output, AW+1: registered count of pending registers.

Function
REQ-017 SHALL return 0 and rd_pending=0 for any read of address 0; writes and issues to address 0 are ignored.
REQ-018 SHALL provide reads combinationally (zero latency) from stored contents.
REQ-019 SHALL, when BYPASS=1, forward wr_data[k] to read port p if wr_en[k], wr_addr[k]==rd_addr[p], address nonzero; highest-index matching write port wins.
REQ-020 SHALL, when BYPASS=0, return pre-write contents in the write cycle; new value visible the next cycle.
REQ-021 SHALL write wr_data[k] into wr_addr[k] at the clock edge when wr_en[k] and address nonzero.
REQ-022 SHALL, when several write ports target the same address in one cycle, store the highest-index port's data.
REQ-023 SHALL set pending[iss_addr] at the edge when iss_en and iss_addr nonzero.
REQ-024 SHALL clear pending[a] at the edge when any enabled write port targets a.
REQ-025 SHALL let set win when issue and write target the same address in the same cycle (new producer).
REQ-026 SHALL drive rd_pending[p]=pending[rd_addr[p]], forced to 0 when BYPASS=1 and a same-cycle write is forwarded to port p.
REQ-027 SHALL update pend_cnt one cycle after the pending vector changes, equal to popcount of pending[NREGS-1:1], never exceeding NREGS-1.
REQ-028 SHALL accept re-issue of an already-pending register without changing pend_cnt.

Reset
REQ-029 SHALL, on rst high at an edge, clear all registers to 0, all pending bits to 0, pend_cnt to 0, in one cycle.
REQ-030 SHALL give rst priority over simultaneous writes and issues; those are discarded.
REQ-031 SHALL keep register 0 reading 0 in simulation from time zero without reset.

Structure
REQ-032 SHALL take XLEN/NREGS/NRD/NWR defaults from the shared core parameter package used by the datapath.
REQ-033 SHALL place pending bits, set/clear priority and pend_cnt in sub-module regfile_scoreboard; data array and bypass stay in regfile_mp.

Verification
REQ-034 SHALL cover: reset, write 0xDEADBEEF to r5 port 0, next cycle read r5 -> 0xDEADBEEF; read r0 after writing 0x1234 to r0 -> 0.
REQ-035 SHALL cover: BYPASS=1, same-cycle write r7=0xA5A5A5A5 and read r7 -> 0xA5A5A5A5 combinationally; BYPASS=0 -> previous value 0.
REQ-036 SHALL cover: ports 0 and 1 both write r3 (0x11, 0x22) -> r3 reads 0x22 next cycle.
REQ-037 SHALL cover: issue r9 -> rd_pending=1, pend_cnt=1 one cycle later; write r9 -> pending clears, pend_cnt=0; same-cycle issue+write r9 -> stays pending.
REQ-038 SHALL cover: issue r1..r31 over 31 cycles -> pend_cnt=31; assert rst mid-sequence with writes active -> all reads 0, pend_cnt=0 next cycle.
